// File: rtl/cl_axil_skid_slice.sv
// AXI4-Lite register slice: one 2-entry skid unit per channel (AW, W, B, AR, R).
// Every output to either side is driven straight from a flop, so no combinational path crosses the slice.

module cl_axil_skid_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic         busy_nxt_o
);

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           in_ready_q, out_valid_q;
  logic           push, pop;

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = FULL1;
          main_d  = in_data_i;
        end
      end
      FULL1: begin
        if (push && pop) begin
          main_d = in_data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (push) begin
          state_d = FULL2;
          skid_d  = in_data_i;
        end
      end
      FULL2: begin
        if (pop) begin
          state_d = FULL1;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      in_ready_q  <= (state_d != FULL2);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // NOTE: the skid entry is never observable before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign busy_nxt_o  = (state_d != EMPTY);

endmodule

module cl_axil_skid_slice #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_sync,
  // slave side (shell)
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // master side (CL register slave)
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic                slc_busy
);

  localparam int STRB_W = DATA_W / 8;

  logic [4:0] busy_nxt;
  logic       slc_busy_q;

  cl_axil_skid_unit #(.W(ADDR_W)) u_aw (
    .clk(clk_main_a0), .rst(rst_main_sync),
    .in_valid_i(s_axi_awvalid), .in_data_i(s_axi_awaddr), .in_ready_o(s_axi_awready),
    .out_valid_o(m_axi_awvalid), .out_data_o(m_axi_awaddr), .out_ready_i(m_axi_awready),
    .busy_nxt_o(busy_nxt[0])
  );

  cl_axil_skid_unit #(.W(DATA_W + STRB_W)) u_w (
    .clk(clk_main_a0), .rst(rst_main_sync),
    .in_valid_i(s_axi_wvalid), .in_data_i({s_axi_wdata, s_axi_wstrb}), .in_ready_o(s_axi_wready),
    .out_valid_o(m_axi_wvalid), .out_data_o({m_axi_wdata, m_axi_wstrb}), .out_ready_i(m_axi_wready),
    .busy_nxt_o(busy_nxt[1])
  );

  // B and R run master-to-slave, so their input side is the m_* port.
  cl_axil_skid_unit #(.W(2)) u_b (
    .clk(clk_main_a0), .rst(rst_main_sync),
    .in_valid_i(m_axi_bvalid), .in_data_i(m_axi_bresp), .in_ready_o(m_axi_bready),
    .out_valid_o(s_axi_bvalid), .out_data_o(s_axi_bresp), .out_ready_i(s_axi_bready),
    .busy_nxt_o(busy_nxt[2])
  );

  cl_axil_skid_unit #(.W(ADDR_W)) u_ar (
    .clk(clk_main_a0), .rst(rst_main_sync),
    .in_valid_i(s_axi_arvalid), .in_data_i(s_axi_araddr), .in_ready_o(s_axi_arready),
    .out_valid_o(m_axi_arvalid), .out_data_o(m_axi_araddr), .out_ready_i(m_axi_arready),
    .busy_nxt_o(busy_nxt[3])
  );

  cl_axil_skid_unit #(.W(DATA_W + 2)) u_r (
    .clk(clk_main_a0), .rst(rst_main_sync),
    .in_valid_i(m_axi_rvalid), .in_data_i({m_axi_rdata, m_axi_rresp}), .in_ready_o(m_axi_rready),
    .out_valid_o(s_axi_rvalid), .out_data_o({s_axi_rdata, s_axi_rresp}), .out_ready_i(s_axi_rready),
    .busy_nxt_o(busy_nxt[4])
  );

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) slc_busy_q <= 1'b0;
    else               slc_busy_q <= |busy_nxt;
  end

  assign slc_busy = slc_busy_q;

endmodule

// File: tb/tb_cl_axil_skid_slice.sv
// Bench for cl_axil_skid_slice: per-channel FIFO reference model (queues of held beats),
// a table of single-channel vectors, hand sequences for write/read/reset corners, and random traffic.

module tb_cl_axil_skid_slice;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [3:0]  s_axi_wstrb, m_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp, m_axi_bresp, m_axi_rresp;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic slc_busy;

  cl_axil_skid_slice dut (
    .clk_main_a0(clk), .rst_main_sync(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .slc_busy(slc_busy)
  );

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R. Payloads packed as the slice packs them.
  localparam int CW [5] = '{32, 36, 2, 32, 34};
  localparam string CN [5] = '{"aw", "w", "b", "ar", "r"};

  logic        drv_valid [5];
  logic        drv_ready [5];
  logic [63:0] drv_pay   [5];
  logic        ob_in_ready [5];
  logic        ob_valid    [5];
  logic [63:0] ob_pay      [5];

  assign s_axi_awvalid = drv_valid[0];
  assign s_axi_awaddr  = drv_pay[0][31:0];
  assign m_axi_awready = drv_ready[0];
  assign s_axi_wvalid  = drv_valid[1];
  assign s_axi_wdata   = drv_pay[1][35:4];
  assign s_axi_wstrb   = drv_pay[1][3:0];
  assign m_axi_wready  = drv_ready[1];
  assign m_axi_bvalid  = drv_valid[2];
  assign m_axi_bresp   = drv_pay[2][1:0];
  assign s_axi_bready  = drv_ready[2];
  assign s_axi_arvalid = drv_valid[3];
  assign s_axi_araddr  = drv_pay[3][31:0];
  assign m_axi_arready = drv_ready[3];
  assign m_axi_rvalid  = drv_valid[4];
  assign m_axi_rdata   = drv_pay[4][33:2];
  assign m_axi_rresp   = drv_pay[4][1:0];
  assign s_axi_rready  = drv_ready[4];

  assign ob_in_ready[0] = s_axi_awready;
  assign ob_in_ready[1] = s_axi_wready;
  assign ob_in_ready[2] = m_axi_bready;
  assign ob_in_ready[3] = s_axi_arready;
  assign ob_in_ready[4] = m_axi_rready;
  assign ob_valid[0] = m_axi_awvalid;
  assign ob_valid[1] = m_axi_wvalid;
  assign ob_valid[2] = s_axi_bvalid;
  assign ob_valid[3] = m_axi_arvalid;
  assign ob_valid[4] = s_axi_rvalid;
  assign ob_pay[0] = {32'b0, m_axi_awaddr};
  assign ob_pay[1] = {28'b0, m_axi_wdata, m_axi_wstrb};
  assign ob_pay[2] = {62'b0, s_axi_bresp};
  assign ob_pay[3] = {32'b0, m_axi_araddr};
  assign ob_pay[4] = {30'b0, s_axi_rdata, s_axi_rresp};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: beats the slice currently holds per channel, oldest first.
  logic [63:0] mq [5][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int c);
    return (64'd1 << CW[c]) - 64'd1;
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  // One clock: record handshakes seen before the edge, advance the model, compare after the edge.
  task automatic tick();
    logic push [5];
    logic pop  [5];
    logic any_busy;
    for (int c = 0; c < 5; c++) begin
      push[c] = drv_valid[c] & ob_in_ready[c];
      pop[c]  = ob_valid[c] & drv_ready[c];
    end
    @(posedge clk);
    #1;
    cyc++;
    any_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rst) begin
        mq[c].delete();
      end else begin
        if (pop[c] && mq[c].size() > 0) void'(mq[c].pop_front());
        if (push[c]) mq[c].push_back(drv_pay[c] & mask_of(c));
      end
      // At most two beats held; the ready flop reflects that, and is low in the cycle after a reset edge.
      check($sformatf("%s_in_ready", CN[c]), 64'(ob_in_ready[c]),
            64'((!rst) && (mq[c].size() < 2)));
      check($sformatf("%s_out_valid", CN[c]), 64'(ob_valid[c]), 64'(mq[c].size() > 0));
      if (mq[c].size() > 0)
        check($sformatf("%s_payload", CN[c]), ob_pay[c], mq[c][0]);
      if (mq[c].size() > 0) any_busy = 1'b1;
    end
    check("slc_busy", 64'(slc_busy), 64'(any_busy));
  endtask

  task automatic idle_all(input logic rdy);
    for (int c = 0; c < 5; c++) begin
      drv_valid[c] = 1'b0;
      drv_pay[c]   = '0;
      drv_ready[c] = rdy;
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic        rdy;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [16];

  logic        pend_v;
  logic [31:0] pend_a;
  int          r_cnt, r_first, r_last;
  logic        acc [5];

  initial begin
    // AR channel vectors: stall into FULL2, drain, then 8 cycles of simultaneous push and pop.
    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10};
    tbl[1] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10};
    tbl[2] = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10};
    tbl[3] = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b1, 32'h14};
    tbl[4] = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b1, 32'h18};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
    for (int k = 6; k < 15; k++)
      tbl[k] = '{1'b1, 32'h20 + 32'(4 * (k - 6)), 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * (k - 6))};
    tbl[15] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};

    // Reset: offered beats must not be taken, everything reads zero.
    rst = 1'b1;
    idle_all(1'b1);
    drv_valid[0] = 1'b1;
    drv_pay[0]   = 64'h1234;
    repeat (3) tick();
    check("rst_awaddr", 64'(m_axi_awaddr), 64'h0);
    check("rst_rdata", 64'(s_axi_rdata), 64'h0);
    check("rst_awready", 64'(s_axi_awready), 64'h0);
    rst = 1'b0;
    drv_valid[0] = 1'b0;
    tick();
    check("post_rst_awready", 64'(s_axi_awready), 64'h1);
    check("post_rst_bready", 64'(m_axi_bready), 64'h1);

    // Table-driven AR vectors.
    idle_all(1'b1);
    for (int i = 0; i < 16; i++) begin
      drv_valid[3] = tbl[i].v;
      drv_pay[3]   = 64'(tbl[i].addr);
      drv_ready[3] = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_arready", i), 64'(s_axi_arready), 64'(tbl[i].exp_in_ready));
      check($sformatf("tbl%0d_arvalid", i), 64'(m_axi_arvalid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        check($sformatf("tbl%0d_araddr", i), 64'(m_axi_araddr), 64'(tbl[i].exp_addr));
    end

    // Single write: AW and W appear one cycle after the handshake, then B back one cycle later.
    idle_all(1'b1);
    drv_valid[0] = 1'b1;
    drv_pay[0]   = 64'h0000_0500;
    drv_valid[1] = 1'b1;
    drv_pay[1]   = {28'b0, 32'hCAFE_F00D, 4'hF};
    tick();
    check("wr_awvalid", 64'(m_axi_awvalid), 64'h1);
    check("wr_awaddr", 64'(m_axi_awaddr), 64'h500);
    check("wr_wvalid", 64'(m_axi_wvalid), 64'h1);
    check("wr_wdata", 64'(m_axi_wdata), 64'hCAFE_F00D);
    check("wr_wstrb", 64'(m_axi_wstrb), 64'hF);
    drv_valid[0] = 1'b0;
    drv_valid[1] = 1'b0;
    tick();
    drv_valid[2] = 1'b1;
    drv_pay[2]   = 64'h0;
    tick();
    check("wr_bvalid", 64'(s_axi_bvalid), 64'h1);
    check("wr_bresp", 64'(s_axi_bresp), 64'h0);
    drv_valid[2] = 1'b0;
    tick();
    check("wr_bvalid_done", 64'(s_axi_bvalid), 64'h0);

    // 16 back-to-back reads against a CL responder that answers one cycle after each AR handshake.
    idle_all(1'b1);
    pend_v = 1'b0;
    pend_a = '0;
    r_cnt = 0;
    r_first = 0;
    r_last = 0;
    for (int k = 0; k < 24; k++) begin
      drv_valid[3] = (k < 16);
      drv_pay[3]   = 64'(32'h100 + 32'(4 * k));
      drv_valid[4] = pend_v;
      drv_pay[4]   = {30'b0, rd_of(pend_a), 2'b00};
      if (s_axi_rvalid) begin
        check("rd_rdata", 64'(s_axi_rdata), 64'(rd_of(32'h100 + 32'(4 * r_cnt))));
        if (r_cnt == 0) r_first = k;
        r_last = k;
        r_cnt++;
      end
      pend_v = m_axi_arvalid;
      pend_a = m_axi_araddr;
      tick();
    end
    check("rd_beats", 64'(r_cnt), 64'd16);
    check("rd_no_bubble", 64'(r_last - r_first), 64'd15);

    // Reset while AW and R each hold two beats.
    idle_all(1'b1);
    drv_ready[0] = 1'b0;
    drv_ready[4] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drv_valid[0] = 1'b1;
      drv_pay[0]   = 64'(32'hA000 + 32'(k));
      drv_valid[4] = 1'b1;
      drv_pay[4]   = {30'b0, 32'hBEEF_0000 + 32'(k), 2'b01};
      tick();
    end
    check("pre_rst_awready", 64'(s_axi_awready), 64'h0);
    check("pre_rst_rready", 64'(m_axi_rready), 64'h0);
    rst = 1'b1;
    tick();
    check("mid_rst_awvalid", 64'(m_axi_awvalid), 64'h0);
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'h0);
    check("mid_rst_arready", 64'(s_axi_arready), 64'h0);
    check("mid_rst_busy", 64'(slc_busy), 64'h0);
    check("mid_rst_awaddr", 64'(m_axi_awaddr), 64'h0);
    rst = 1'b0;
    drv_valid[0] = 1'b0;
    drv_valid[4] = 1'b0;
    drv_ready[0] = 1'b1;
    drv_ready[4] = 1'b1;
    tick();
    check("after_rst_awready", 64'(s_axi_awready), 64'h1);
    check("after_rst_rready", 64'(m_axi_rready), 64'h1);
    repeat (4) tick();
    check("no_stale_aw", 64'(m_axi_awvalid), 64'h0);
    check("no_stale_r", 64'(s_axi_rvalid), 64'h0);

    // Random traffic on all channels; sources hold valid and payload until accepted.
    idle_all(1'b0);
    for (int n = 0; n < 8000; n++) begin
      for (int c = 0; c < 5; c++) acc[c] = drv_valid[c] & ob_in_ready[c];
      if (n > 0) tick();
      for (int c = 0; c < 5; c++) begin
        if (acc[c] || !drv_valid[c]) begin
          drv_valid[c] = 1'($urandom_range(0, 1));
          drv_pay[c]   = {$urandom(), $urandom()} & mask_of(c);
        end
        drv_ready[c] = 1'($urandom_range(0, 1));
      end
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
